pipe_checker: RTL and testbench

PIPE_CHECKER -- requirements
Module: pipe_checker

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_checker.sv | 156 +++++++++++++++
 tb/tb_pipe_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline checker: default geometry, FSM state
// encoding and the scoreboard slot record.
package pipe_pkg;

  localparam int DEPTH = 5;
  localparam int SHIFT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] exp;
  } slot_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count up on i_inc, holding once every bit is set.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_checker.sv
// Shadow scoreboard for a DEPTH-stage shifting pipeline. Each accepted input
// is pre-shifted by DEPTH*SHIFT and walked through DEPTH slots in lock-step
// with the real pipeline; when it reaches the last slot, the pipeline output
// is compared against it.
//
// Handshake: there is no back-pressure. On a rising edge with en=1 the
// pipeline and the scoreboard both advance one position, and data_in is
// captured as a real entry when in_valid=1 (a bubble otherwise). With en=0
// everything holds and no comparison is made. clr flushes both together.
module pipe_checker
  import pipe_pkg::*;
#(
  parameter int DEPTH = pipe_pkg::DEPTH,
  parameter int SHIFT = pipe_pkg::SHIFT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             in_valid,
  input  logic [31:0]      data_in,
  input  logic [31:0]      pipe_q,
  output logic [31:0]      expected,
  output logic             check_valid,
  output logic             mismatch,
  output logic             err,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      first_err_data,
  output logic [1:0]       state
);

  localparam int TOTAL_SHIFT = DEPTH * SHIFT;

  slot_t       r_slot [DEPTH];
  state_t      r_state;
  state_t      w_state_next;
  logic        r_check_valid;
  logic        r_mismatch;
  logic        r_err;
  logic [31:0] r_first_err_data;

  logic [31:0] w_load_exp;
  logic [31:0] w_expected;
  logic        w_check;
  logic        w_mismatch;
  logic        w_pass;
  logic        w_any_upstream;
  logic        w_next_any;

  // Bits shifted past bit 31 are simply lost, matching the real datapath.
  assign w_load_exp = data_in << TOTAL_SHIFT;

  assign w_expected = r_slot[DEPTH-1].valid ? r_slot[DEPTH-1].exp : 32'd0;
  assign w_check    = en && r_slot[DEPTH-1].valid;
  assign w_mismatch = w_check && (pipe_q != w_expected);
  assign w_pass     = w_check && !w_mismatch;

  // Scoreboard shift register: advance on en, hold otherwise, flush on clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= '0;
      end
    end else if (en) begin
      r_slot[0] <= {in_valid, w_load_exp};
      for (int i = 1; i < DEPTH; i++) begin
        r_slot[i] <= r_slot[i-1];
      end
    end
  end

  // Does any slot other than the last one hold a live entry?
  always_comb begin
    w_any_upstream = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_any_upstream = w_any_upstream | r_slot[i].valid;
    end
  end

  // Whether any slot will be valid once this edge has been taken.
  assign w_next_any = en ? (in_valid || w_any_upstream)
                         : (w_any_upstream || r_slot[DEPTH-1].valid);

  // Check result pulses, sticky error flag and first failing value.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_check_valid    <= 1'b0;
      r_mismatch       <= 1'b0;
      r_err            <= 1'b0;
      r_first_err_data <= 32'd0;
    end else begin
      r_check_valid <= w_check;
      r_mismatch    <= w_mismatch;
      if (w_mismatch) begin
        r_err <= 1'b1;
        if (!r_err) begin
          r_first_err_data <= pipe_q;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: a mismatch wins everywhere, ERROR is terminal until clr.
  always_comb begin
    w_state_next = r_state;
    if (w_mismatch) begin
      w_state_next = ST_ERROR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && en) w_state_next = ST_FILL;
        end
        ST_FILL: begin
          if (en && r_slot[DEPTH-2].valid) w_state_next = ST_RUN;
          else if (!w_next_any)            w_state_next = ST_IDLE;
        end
        ST_RUN: begin
          if (!w_next_any) w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_ERROR;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .i_clk   (clk),
    .i_clr   (clr),
    .i_inc   (w_pass),
    .o_count (match_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .i_clk   (clk),
    .i_clr   (clr),
    .i_inc   (w_mismatch),
    .o_count (err_count)
  );

  assign expected       = w_expected;
  assign check_valid    = r_check_valid;
  assign mismatch       = r_mismatch;
  assign err            = r_err;
  assign first_err_data = r_first_err_data;
  assign state          = r_state;

endmodule

// File: tb/tb_pipe_checker.sv
// Bench for pipe_checker: a stand-in shifting pipeline drives pipe_q, a
// queue-based reference model predicts every output, and a vector table plus
// hand sequences pin down the named scenarios.
module tb_pipe_checker;

  localparam int D  = 5;
  localparam int S  = 1;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic          en;
  logic          in_valid;
  logic [31:0]   data_in;
  logic [31:0]   pipe_q;
  logic [31:0]   expected;
  logic          check_valid;
  logic          mismatch;
  logic          err;
  logic [CW-1:0] match_count;
  logic [CW-1:0] err_count;
  logic [31:0]   first_err_data;
  logic [1:0]    state;

  pipe_checker #(.DEPTH(D), .SHIFT(S), .CNT_W(CW)) dut (
    .clk            (clk),
    .clr            (clr),
    .en             (en),
    .in_valid       (in_valid),
    .data_in        (data_in),
    .pipe_q         (pipe_q),
    .expected       (expected),
    .check_valid    (check_valid),
    .mismatch       (mismatch),
    .err            (err),
    .match_count    (match_count),
    .err_count      (err_count),
    .first_err_data (first_err_data),
    .state          (state)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stand-in for the pipeline under check
  logic [31:0] pl  [D];
  logic        plv [D];

  // reference model: in-flight entries, oldest first, with their slot index
  typedef struct {
    logic [31:0] exp;
    int          age;
  } ent_t;
  ent_t          mq[$];
  logic          m_cv, m_mm, m_err;
  logic [CW-1:0] m_mc, m_ec;
  logic [31:0]   m_fed;
  logic [1:0]    m_st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] m_expected();
    if (mq.size() > 0 && mq[0].age == D - 1) return mq[0].exp;
    return 32'd0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cv = 0; m_mm = 0; m_err = 0; m_mc = '0; m_ec = '0; m_fed = '0; m_st = 2'd0;
    for (int i = 0; i < D; i++) begin pl[i] = '0; plv[i] = 1'b0; end
  endtask

  // One clock edge of the reference model, from the pre-edge inputs.
  task automatic model_edge(input logic c, input logic e, input logic v,
                            input logic [31:0] d, input logic [31:0] pq);
    logic chk, mis, stage_dm2, any_after;
    if (c) begin
      model_reset();
      return;
    end
    chk = e && mq.size() > 0 && mq[0].age == D - 1;
    mis = chk && (pq != m_expected());
    stage_dm2 = 1'b0;
    any_after = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].age == D - 2) stage_dm2 = 1'b1;
      if (mq[i].age <  D - 1) any_after = 1'b1;
    end
    any_after = e ? (any_after || v) : (mq.size() > 0);
    if (mis)                m_st = 2'd3;
    else if (m_st == 2'd0)  begin if (v && e) m_st = 2'd1; end
    else if (m_st == 2'd1)  begin
      if (e && stage_dm2)   m_st = 2'd2;
      else if (!any_after)  m_st = 2'd0;
    end
    else if (m_st == 2'd2)  begin if (!any_after) m_st = 2'd0; end
    m_cv = chk;
    m_mm = mis;
    if (chk && !mis && m_mc != {CW{1'b1}}) m_mc = m_mc + 1'b1;
    if (mis && m_ec != {CW{1'b1}})         m_ec = m_ec + 1'b1;
    if (mis && !m_err) m_fed = pq;
    if (mis) m_err = 1'b1;
    if (e) begin
      if (chk) void'(mq.pop_front());
      foreach (mq[i]) mq[i].age++;
      if (v) mq.push_back('{d << (D * S), 0});
      for (int i = D - 1; i > 0; i--) begin pl[i] = pl[i-1] << S; plv[i] = plv[i-1]; end
      pl[0] = d << S;
      plv[0] = v;
    end
  endtask

  // driver: apply one cycle of inputs, check comb output before the edge and
  // every registered output after it
  task automatic step(input logic c, input logic e, input logic v,
                      input logic [31:0] d, input logic [31:0] mask,
                      output logic [31:0] pre_exp);
    clr = c; en = e; in_valid = v; data_in = d;
    pipe_q = plv[D-1] ? (pl[D-1] ^ mask) : $urandom();
    #1;
    pre_exp = expected;
    check("expected", expected, m_expected());
    @(posedge clk);
    model_edge(c, e, v, d, pipe_q);
    #1;
    check("check_valid", {31'd0, check_valid}, {31'd0, m_cv});
    check("mismatch", {31'd0, mismatch}, {31'd0, m_mm});
    check("err", {31'd0, err}, {31'd0, m_err});
    check("match_count", {16'd0, match_count}, {16'd0, m_mc});
    check("err_count", {16'd0, err_count}, {16'd0, m_ec});
    check("first_err_data", first_err_data, m_fed);
    check("state", {30'd0, state}, {30'd0, m_st});
  endtask

  typedef struct {
    logic          c, e, v;
    logic [31:0]   d, mask, x_exp;
    logic          x_cv, x_mm, x_err;
    logic [CW-1:0] x_mc, x_ec;
    logic [1:0]    x_st;
    logic [31:0]   x_fed;
  } vec_t;
  vec_t vt[$];

  function automatic void add(logic c, logic e, logic v, logic [31:0] d, logic [31:0] mask,
                              logic [31:0] x_exp, logic x_cv, logic x_mm, logic x_err,
                              logic [CW-1:0] x_mc, logic [CW-1:0] x_ec, logic [1:0] x_st,
                              logic [31:0] x_fed);
    vt.push_back('{c, e, v, d, mask, x_exp, x_cv, x_mm, x_err, x_mc, x_ec, x_st, x_fed});
  endfunction

  logic [31:0] pe;
  int          pulses, pulse_edge;

  initial begin
    // reset block
    clr = 1'b1; en = 1'b0; in_valid = 1'b0; data_in = '0; pipe_q = '0;
    model_reset();
    @(posedge clk); #1;
    check("reset_expected", expected, 32'd0);
    check("reset_check_valid", {31'd0, check_valid}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_counts", {match_count, err_count}, 32'd0);
    check("reset_first_err", first_err_data, 32'd0);
    check("reset_state", {30'd0, state}, 32'd0);

    // vectors: basic pass, shift truncation, mismatch, later mismatch
    add(0,1,1,32'h1,0, 0, 0,0,0, 0,0, 2'd1, 0);
    for (int k = 0; k < 3; k++) add(0,1,0,0,0, 0, 0,0,0, 0,0, 2'd1, 0);
    add(0,1,0,0,0, 0, 0,0,0, 0,0, 2'd2, 0);
    add(0,1,0,0,0, 32'h20, 1,0,0, 1,0, 2'd0, 0);
    add(0,1,0,0,0, 0, 0,0,0, 1,0, 2'd0, 0);
    add(0,1,1,32'h08000001,0, 0, 0,0,0, 1,0, 2'd1, 0);
    for (int k = 0; k < 3; k++) add(0,1,0,0,0, 0, 0,0,0, 1,0, 2'd1, 0);
    add(0,1,0,0,0, 0, 0,0,0, 1,0, 2'd2, 0);
    add(0,1,0,0,0, 32'h20, 1,0,0, 2,0, 2'd0, 0);
    add(0,1,1,32'h3,0, 0, 0,0,0, 2,0, 2'd1, 0);
    for (int k = 0; k < 3; k++) add(0,1,0,0,0, 0, 0,0,0, 2,0, 2'd1, 0);
    add(0,1,0,0,0, 0, 0,0,0, 2,0, 2'd2, 0);
    add(0,1,0,0,32'h1, 32'h60, 1,1,1, 2,1, 2'd3, 32'h61);
    add(0,1,0,0,0, 0, 0,0,1, 2,1, 2'd3, 32'h61);
    add(0,1,1,32'h1,0, 0, 0,0,1, 2,1, 2'd3, 32'h61);
    for (int k = 0; k < 4; k++) add(0,1,0,0,0, 0, 0,0,1, 2,1, 2'd3, 32'h61);
    add(0,1,0,0,32'h2, 32'h20, 1,1,1, 2,2, 2'd3, 32'h61);

    foreach (vt[i]) begin
      step(vt[i].c, vt[i].e, vt[i].v, vt[i].d, vt[i].mask, pe);
      check($sformatf("vec%0d_expected", i), pe, vt[i].x_exp);
      check($sformatf("vec%0d_flags", i), {29'd0, check_valid, mismatch, err},
            {29'd0, vt[i].x_cv, vt[i].x_mm, vt[i].x_err});
      check($sformatf("vec%0d_counts", i), {match_count, err_count}, {vt[i].x_mc, vt[i].x_ec});
      check($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, vt[i].x_st});
      check($sformatf("vec%0d_first_err", i), first_err_data, vt[i].x_fed);
    end

    // stall: three disabled edges after edge 2; one check, on edge 8
    step(1,0,0,0,0,pe);
    step(0,1,1,32'h3,0,pe);
    pulses = 0; pulse_edge = 0;
    for (int k = 1; k <= 10; k++) begin
      step(0, (k >= 3 && k <= 5) ? 1'b0 : 1'b1, 0, 0, 0, pe);
      if (check_valid) begin pulses++; pulse_edge = k; end
    end
    check("stall_pulses", pulses, 1);
    check("stall_edge", pulse_edge, 8);
    check("stall_match_count", {16'd0, match_count}, 32'd1);

    // mid-flight clear: three entries discarded, never checked
    step(1,0,0,0,0,pe);
    for (int k = 0; k < 3; k++) step(0,1,1,$urandom(),0,pe);
    step(1,1,1,32'h5,0,pe);
    check("flush_outputs", {expected | first_err_data}, 32'd0);
    check("flush_flags", {check_valid, mismatch, err, state, match_count, err_count}, 0);
    pulses = 0;
    for (int k = 0; k < D + 3; k++) begin
      step(0,1,0,0,0,pe);
      if (check_valid) pulses++;
    end
    check("flush_no_pulse", pulses, 0);

    // randomized traffic with occasional corruption and clears
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0,199) == 0), ($urandom_range(0,3) != 0), $urandom_range(0,1),
           $urandom(), ($urandom_range(0,15) == 0) ? (32'h1 << $urandom_range(0,31)) : 32'h0, pe);
    end

    // saturation: 65537 passing entries back to back
    step(1,0,0,0,0,pe);
    for (int k = 0; k < 65537; k++) step(0,1,1,$urandom(),0,pe);
    for (int k = 0; k < D; k++) step(0,1,0,0,0,pe);
    check("sat_match_count", {16'd0, match_count}, 32'h0000FFFF);
    check("sat_err_count", {16'd0, err_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
